// File: rtl/knight_action_if.sv
// Command bus between the knight action sequencer and the movement datapath.
// master: the side that supplies keys and position feedback.
// slave : the action controller, which returns motion and status commands.
interface knight_action_if;
  logic [7:0] keycode;
  logic       on_ground;
  logic [9:0] y_pos;
  logic [9:0] x_motion;
  logic [9:0] y_motion;
  logic [3:0] status;
  logic       inverse;
  logic       attack_hit;

  modport master (
    output keycode, on_ground, y_pos,
    input  x_motion, y_motion, status, inverse, attack_hit
  );

  modport slave (
    input  keycode, on_ground, y_pos,
    output x_motion, y_motion, status, inverse, attack_hit
  );
endinterface

// File: rtl/knight_action_ctrl.sv
// Per-frame action sequencer for the knight: decodes the current key into a
// single prioritised action and steps the idle/walk/jump/fall/attack machine.
// Also owns jump apex detection, attack phase timing and attack cooldown.
// All outputs are registered and describe the state entered at each edge.
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while
// airborne. The extra jump is re-armed only by landing.
module knight_action_ctrl #(
  parameter int WALK_SPEED      = 2,
  parameter int JUMP_SPEED      = 6,
  parameter int FALL_SPEED      = 6,
  parameter int JUMP_HEIGHT     = 215,
  parameter int MAX_JUMP_FRAMES = 40,
  parameter int ATK_WINDUP      = 2,
  parameter int ATK_ACTIVE      = 3,
  parameter int ATK_RECOVER     = 4,
  parameter int ATK_COOLDOWN    = 8
) (
  input  logic           frame_clk,
  input  logic           Reset,
  knight_action_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_JUMP   = 3'd2,
    ST_FALL   = 3'd3,
    ST_ATTACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_DOWN,
    ACT_JUMP,
    ACT_ATTACK
  } action_t;

  localparam logic [7:0] KEY_LEFT   = 8'h50;
  localparam logic [7:0] KEY_RIGHT  = 8'h4F;
  localparam logic [7:0] KEY_DOWN   = 8'h51;
  localparam logic [7:0] KEY_JUMP   = 8'h52;
  localparam logic [7:0] KEY_ATTACK = 8'h1B;

  // Motion steps, sign-extended to the 10-bit command width.
  localparam logic [9:0] X_RIGHT = 10'(WALK_SPEED);
  localparam logic [9:0] X_LEFT  = 10'(-WALK_SPEED);
  localparam logic [9:0] Y_RISE  = 10'(-JUMP_SPEED);
  localparam logic [9:0] Y_FALL  = 10'(FALL_SPEED);

  localparam logic [7:0] JUMP_LAST     = 8'(MAX_JUMP_FRAMES - 1);
  localparam logic [7:0] ATK_LAST      = 8'(ATK_WINDUP + ATK_ACTIVE + ATK_RECOVER - 1);
  localparam logic [7:0] HIT_START     = 8'(ATK_WINDUP);
  localparam logic [7:0] HIT_END       = 8'(ATK_WINDUP + ATK_ACTIVE);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(ATK_COOLDOWN);
  localparam logic       HIT_AT_ZERO   = (ATK_WINDUP == 0) && (ATK_ACTIVE > 0);

  state_t     state_q;
  logic [7:0] prev_key_q;
  logic [7:0] jump_cnt_q;
  logic [7:0] atk_cnt_q;
  logic [7:0] cooldown_q;
  logic [9:0] x_motion_q;
  logic [9:0] y_motion_q;
  logic [3:0] status_q;
  logic       inverse_q;
  logic       attack_hit_q;

  action_t    action_d;
  logic [9:0] steer_x_d;
  logic       steer_inv_d;
  logic [9:0] apex_d;
  logic       jump_exit_d;
  logic       extra_jump_d;
  logic [7:0] atk_next_d;
  logic       hit_next_d;

`ifdef DOUBLE_JUMP_EN
  localparam logic [9:0] APEX_FIRST  = 10'(JUMP_HEIGHT);
  localparam logic [9:0] APEX_SECOND = 10'(JUMP_HEIGHT - 40);
  logic dj_used_q;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode the key into one action: attack > jump > down > left/right.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    action_d = ACT_NONE;
    if (bus.keycode == KEY_ATTACK) begin
      if (cooldown_q == 8'd0) action_d = ACT_ATTACK;
    end else if (bus.keycode == KEY_JUMP) begin
      if (prev_key_q != KEY_JUMP) action_d = ACT_JUMP;
    end else if (bus.keycode == KEY_DOWN) begin
      action_d = ACT_DOWN;
    end else if (bus.keycode == KEY_LEFT) begin
      action_d = ACT_LEFT;
    end else if (bus.keycode == KEY_RIGHT) begin
      action_d = ACT_RIGHT;
    end
  end

  // Horizontal steering shared by walking and air control; facing holds on none.
  always_comb begin
    steer_x_d   = 10'd0;
    steer_inv_d = inverse_q;
    if (action_d == ACT_LEFT) begin
      steer_x_d   = X_LEFT;
      steer_inv_d = 1'b1;
    end else if (action_d == ACT_RIGHT) begin
      steer_x_d   = X_RIGHT;
      steer_inv_d = 1'b0;
    end
  end

  // Apex target, rise-termination test, extra-jump request and attack phase.
  always_comb begin
`ifdef DOUBLE_JUMP_EN
    apex_d       = dj_used_q ? APEX_SECOND : APEX_FIRST;
    extra_jump_d = (action_d == ACT_JUMP) && !dj_used_q;
`else
    apex_d       = 10'(JUMP_HEIGHT);
    extra_jump_d = 1'b0;
`endif
    jump_exit_d = (bus.y_pos <= apex_d) || (action_d == ACT_DOWN) ||
                  (jump_cnt_q == JUMP_LAST);
    atk_next_d  = sat_inc(atk_cnt_q);
    hit_next_d  = (atk_next_d >= HIT_START) && (atk_next_d < HIT_END);
  end

  // Action state machine with registered motion/status commands.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      prev_key_q   <= 8'd0;
      jump_cnt_q   <= 8'd0;
      atk_cnt_q    <= 8'd0;
      cooldown_q   <= 8'd0;
      x_motion_q   <= 10'd0;
      y_motion_q   <= 10'd0;
      status_q     <= 4'd0;
      inverse_q    <= 1'b0;
      attack_hit_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      dj_used_q    <= 1'b0;
`endif
    end else begin
      prev_key_q   <= bus.keycode;
      attack_hit_q <= 1'b0;
      // NOTE: non-blocking assignments here, so a later assignment in this
      // block (the cooldown load on attack exit) overrides this decrement.
      if (cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;

      case (state_q)
        ST_IDLE, ST_WALK: begin
          y_motion_q <= 10'd0;
          if (!bus.on_ground) begin
            state_q    <= ST_FALL;
            status_q   <= 4'(ST_FALL);
            y_motion_q <= Y_FALL;
            x_motion_q <= steer_x_d;
            inverse_q  <= steer_inv_d;
          end else if (action_d == ACT_ATTACK) begin
            state_q      <= ST_ATTACK;
            status_q     <= 4'(ST_ATTACK);
            atk_cnt_q    <= 8'd0;
            x_motion_q   <= 10'd0;
            attack_hit_q <= HIT_AT_ZERO;
          end else if (action_d == ACT_JUMP) begin
            state_q    <= ST_JUMP;
            status_q   <= 4'(ST_JUMP);
            jump_cnt_q <= 8'd0;
            x_motion_q <= 10'd0;
            y_motion_q <= Y_RISE;
          end else if ((action_d == ACT_LEFT) || (action_d == ACT_RIGHT)) begin
            state_q    <= ST_WALK;
            status_q   <= 4'(ST_WALK);
            x_motion_q <= steer_x_d;
            inverse_q  <= steer_inv_d;
          end else begin
            state_q    <= ST_IDLE;
            status_q   <= 4'(ST_IDLE);
            x_motion_q <= 10'd0;
          end
        end

        ST_JUMP: begin
          x_motion_q <= steer_x_d;
          inverse_q  <= steer_inv_d;
          if (extra_jump_d) begin
            state_q    <= ST_JUMP;
            status_q   <= 4'(ST_JUMP);
            jump_cnt_q <= 8'd0;
            y_motion_q <= Y_RISE;
`ifdef DOUBLE_JUMP_EN
            dj_used_q  <= 1'b1;
`endif
          end else if (jump_exit_d) begin
            state_q    <= ST_FALL;
            status_q   <= 4'(ST_FALL);
            jump_cnt_q <= sat_inc(jump_cnt_q);
            y_motion_q <= Y_FALL;
          end else begin
            jump_cnt_q <= sat_inc(jump_cnt_q);
            y_motion_q <= Y_RISE;
          end
        end

        ST_FALL: begin
          if (bus.on_ground) begin
            // Landing wins over any key pressed this frame.
            state_q    <= ST_IDLE;
            status_q   <= 4'(ST_IDLE);
            x_motion_q <= 10'd0;
            y_motion_q <= 10'd0;
`ifdef DOUBLE_JUMP_EN
            dj_used_q  <= 1'b0;
`endif
          end else if (extra_jump_d) begin
            state_q    <= ST_JUMP;
            status_q   <= 4'(ST_JUMP);
            jump_cnt_q <= 8'd0;
            x_motion_q <= 10'd0;
            y_motion_q <= Y_RISE;
`ifdef DOUBLE_JUMP_EN
            dj_used_q  <= 1'b1;
`endif
          end else begin
            x_motion_q <= steer_x_d;
            inverse_q  <= steer_inv_d;
            y_motion_q <= Y_FALL;
          end
        end

        ST_ATTACK: begin
          x_motion_q <= 10'd0;
          y_motion_q <= 10'd0;
          if (!bus.on_ground) begin
            state_q    <= ST_FALL;
            status_q   <= 4'(ST_FALL);
            y_motion_q <= Y_FALL;
            cooldown_q <= COOLDOWN_LOAD;
          end else if (atk_cnt_q == ATK_LAST) begin
            state_q    <= ST_IDLE;
            status_q   <= 4'(ST_IDLE);
            cooldown_q <= COOLDOWN_LOAD;
          end else begin
            atk_cnt_q    <= atk_next_d;
            attack_hit_q <= hit_next_d;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          status_q   <= 4'(ST_IDLE);
          x_motion_q <= 10'd0;
          y_motion_q <= 10'd0;
        end
      endcase
    end
  end

  assign bus.x_motion   = x_motion_q;
  assign bus.y_motion   = y_motion_q;
  assign bus.status     = status_q;
  assign bus.inverse    = inverse_q;
  assign bus.attack_hit = attack_hit_q;

endmodule

// File: tb/tb_knight_action_ctrl.sv
// Directed bench for knight_action_ctrl: walk, jump apex, jump frame limit,
// attack phases with cooldown, attack interrupted by leaving the ground, and
// airborne jump edges (extra jump only when DOUBLE_JUMP_EN is defined).
module tb_knight_action_ctrl;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  knight_action_if bus ();

  knight_action_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  // Hard stop in case something in the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one frame; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  int rise_ys [4] = '{377, 300, 250, 221};
  int rising;

  initial begin
    bus.keycode   = 8'h00;
    bus.on_ground = 1'b1;
    bus.y_pos     = 10'd377;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_status", bus.status, 4'd0);
    check("rst_x", bus.x_motion, 10'd0);

    // Walk left for three frames, then release.
    bus.keycode = 8'h50;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("walkl_status", bus.status, 4'd1);
      check("walkl_x", bus.x_motion, 10'h3FE);
      check("walkl_inv", bus.inverse, 1'b1);
    end
    bus.keycode = 8'h00;
    tick();
    check("release_status", bus.status, 4'd0);
    check("release_x", bus.x_motion, 10'd0);

    // Jump, steer left in the air, then reset for two frames mid-jump.
    bus.keycode = 8'h52;
    tick();
    check("jump0_status", bus.status, 4'd2);
    check("jump0_y", bus.y_motion, 10'h3FA);
    bus.on_ground = 1'b0;
    bus.keycode   = 8'h50;
    tick();
    check("air_steer_x", bus.x_motion, 10'h3FE);
    Reset = 1'b1;
    tick();
    tick();
    Reset         = 1'b0;
    bus.keycode   = 8'h00;
    bus.on_ground = 1'b1;
    check("midjump_rst_status", bus.status, 4'd0);
    check("midjump_rst_x", bus.x_motion, 10'd0);
    check("midjump_rst_y", bus.y_motion, 10'd0);
    check("midjump_rst_inv", bus.inverse, 1'b0);
    check("midjump_rst_hit", bus.attack_hit, 1'b0);

    // Jump key held 10 frames while y_pos rises to the apex.
    bus.keycode = 8'h52;
    tick();
    check("apex_j_status", bus.status, 4'd2);
    bus.on_ground = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.y_pos = 10'(rise_ys[i]);
      tick();
      check("apex_rise_status", bus.status, 4'd2);
      check("apex_rise_y", bus.y_motion, 10'h3FA);
    end
    bus.y_pos = 10'd215;
    tick();
    check("apex_fall_status", bus.status, 4'd3);
    check("apex_fall_y", bus.y_motion, 10'd6);
    for (int i = 0; i < 4; i++) begin
      bus.y_pos = 10'd221;
      tick();
      check("held_no_rejump", bus.status, 4'd3);
    end
    bus.on_ground = 1'b1;
    bus.keycode   = 8'h00;
    tick();
    check("land_status", bus.status, 4'd0);
    check("land_y", bus.y_motion, 10'd0);

    // Jump with y_pos frozen low: the frame limit ends the rise.
    bus.y_pos   = 10'd377;
    bus.keycode = 8'h52;
    tick();
    rising        = (bus.status == 4'd2) ? 1 : 0;
    bus.on_ground = 1'b0;
    bus.keycode   = 8'h00;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.status != 4'd2) break;
      rising++;
    end
    check("max_jump_frames", rising, 40);
    check("max_jump_fall", bus.status, 4'd3);
    bus.on_ground = 1'b1;
    tick();
    check("land2_status", bus.status, 4'd0);

    // Right walk and down key on the ground.
    bus.keycode = 8'h4F;
    tick();
    check("walkr_status", bus.status, 4'd1);
    check("walkr_x", bus.x_motion, 10'd2);
    check("walkr_inv", bus.inverse, 1'b0);
    bus.keycode = 8'h51;
    tick();
    check("down_idle", bus.status, 4'd0);

    // Attack held: 9 attack frames, hit on frames 3..5, then cooldown.
    bus.keycode = 8'h1B;
    for (int f = 1; f <= 9; f++) begin
      tick();
      check("atk_status", bus.status, 4'd4);
      check("atk_hit", bus.attack_hit, (f >= 3 && f <= 5) ? 1'b1 : 1'b0);
    end
    tick();
    check("atk_exit", bus.status, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("cooldown_ignore", bus.status, 4'd0);
    end
    tick();
    check("atk_again", bus.status, 4'd4);

    // Leave the ground at atk_cnt = 3.
    tick();
    tick();
    tick();
    check("atk_cnt3_hit", bus.attack_hit, 1'b1);
    bus.on_ground = 1'b0;
    tick();
    check("atk_abort_status", bus.status, 4'd3);
    check("atk_abort_hit", bus.attack_hit, 1'b0);
    check("atk_abort_y", bus.y_motion, 10'd6);

    // Airborne jump edges.
    bus.keycode = 8'h52;
    tick();
`ifdef DOUBLE_JUMP_EN
    check("dj_second", bus.status, 4'd2);
    check("dj_second_y", bus.y_motion, 10'h3FA);
`else
    check("air_jump_ignored", bus.status, 4'd3);
`endif
    bus.keycode = 8'h51;
    tick();
    check("air_down", bus.status, 4'd3);
    bus.keycode = 8'h52;
    tick();
    check("third_jump_ignored", bus.status, 4'd3);
    bus.keycode   = 8'h50;
    bus.on_ground = 1'b1;
    tick();
    check("land_overrides_key", bus.status, 4'd0);
    check("land_overrides_x", bus.x_motion, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
